// File: rtl/div_if.sv
// Execute-stage <-> divider handshake: operands and control in, 64-bit result and ready out.
interface div_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o
  );
endinterface

// File: rtl/div.sv
// Radix-2 restoring 32-bit divider, one quotient bit per cycle; result = {remainder, quotient}.
// Signed mode truncates toward zero and gives the remainder the dividend's sign.
module div (
  input  logic clk,
  input  logic rst,
  div_if.slave bus
);

  localparam logic [1:0] S_FREE   = 2'd0;
  localparam logic [1:0] S_BYZERO = 2'd1;
  localparam logic [1:0] S_ON     = 2'd2;
  localparam logic [1:0] S_END    = 2'd3;

  logic [1:0]  state_q,    state_d;
  logic [5:0]  cnt_q,      cnt_d;
  logic [64:0] dividend_q, dividend_d;
  logic [31:0] divisor_q,  divisor_d;
  logic        n1_q,       n1_d;
  logic        n2_q,       n2_d;
  logic [63:0] result_q,   result_d;
  logic        ready_q,    ready_d;

  logic        sgn;
  logic [31:0] a_abs;
  logic [31:0] b_abs;
  logic [32:0] diff;
  logic [31:0] q_fix;
  logic [31:0] r_fix;

  // The signed flag only matters at load time, so it folds into n1/n2 instead of its own register.
  assign sgn   = bus.signed_div_i;
  assign a_abs = (sgn & bus.opdata1_i[31]) ? -bus.opdata1_i : bus.opdata1_i;
  assign b_abs = (sgn & bus.opdata2_i[31]) ? -bus.opdata2_i : bus.opdata2_i;
  assign diff  = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  assign q_fix = (n1_q ^ n2_q) ? -dividend_q[31:0]  : dividend_q[31:0];
  assign r_fix = n1_q          ? -dividend_q[64:33] : dividend_q[64:33];

  always_comb begin
    // NOTE: every *_d gets a default up front so no path through the case infers a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    n1_d       = n1_q;
    n2_d       = n2_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      S_FREE: begin
        if (bus.start_i && !bus.annul_i) begin
          if (bus.opdata2_i == 32'd0) begin
            state_d = S_BYZERO;
          end else begin
            state_d    = S_ON;
            n1_d       = sgn & bus.opdata1_i[31];
            n2_d       = sgn & bus.opdata2_i[31];
            dividend_d = {32'd0, a_abs, 1'b0};
            divisor_d  = b_abs;
            cnt_d      = 6'd0;
          end
        end
      end
      S_BYZERO: begin
        dividend_d = '0;
        state_d    = S_END;
        ready_d    = 1'b1;
        result_d   = '0;
      end
      S_ON: begin
        if (bus.annul_i) begin
          state_d  = S_FREE;
          cnt_d    = 6'd0;
          ready_d  = 1'b0;
          result_d = '0;
        end else if (cnt_q < 6'd32) begin
          // Borrow out of the trial subtraction means the divisor did not fit: shift in a 0.
          if (diff[32]) dividend_d = {dividend_q[63:0], 1'b0};
          else          dividend_d = {diff[31:0], dividend_q[31:0], 1'b1};
          cnt_d = cnt_q + 6'd1;
        end else begin
          result_d = {r_fix, q_fix};
          ready_d  = 1'b1;
          state_d  = S_END;
          cnt_d    = 6'd0;
        end
      end
      S_END: begin
        if (!bus.start_i) begin
          state_d  = S_FREE;
          ready_d  = 1'b0;
          result_d = '0;
        end
      end
      default: state_d = S_FREE;
    endcase
  end

  // NOTE: sequential state uses <= so every register samples the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_FREE;
      cnt_q    <= 6'd0;
      result_q <= '0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  // NOTE: datapath registers are left unreset; they are always reloaded before use in FREE.
  always_ff @(posedge clk) begin
    dividend_q <= dividend_d;
    divisor_q  <= divisor_d;
    n1_q       <= n1_d;
    n2_q       <= n2_d;
  end

  assign bus.result_o = result_q;
  assign bus.ready_o  = ready_q;

endmodule

// File: tb/tb_div.sv
// Directed bench for div: unsigned/signed cases, divide-by-zero, annul, overflow hold, mid-op reset.
module tb_div;

  logic clk;
  logic rst;
  int   tests_run;
  int   tests_failed;
  logic seen_ready;

  div_if dif ();

  div dut (
    .clk (clk),
    .rst (rst),
    .bus (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus and sampling both happen on the falling edge, half a cycle from the active edge.
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic sgn, input logic [31:0] a, input logic [31:0] b);
    dif.signed_div_i = sgn;
    dif.opdata1_i    = a;
    dif.opdata2_i    = b;
    dif.start_i      = 1'b1;
    dif.annul_i      = 1'b0;
  endtask

  // Full normal-path transaction: busy after E32, valid after E33, released one edge after start drops.
  task automatic do_div(input string tag, input logic sgn, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    drive(sgn, a, b);
    tick(33);
    check({tag, "_busy_ready"}, {63'd0, dif.ready_o}, 64'd0);
    check({tag, "_busy_result"}, dif.result_o, 64'd0);
    tick(1);
    check({tag, "_ready"}, {63'd0, dif.ready_o}, 64'd1);
    check({tag, "_result"}, dif.result_o, exp);
    dif.start_i = 1'b0;
    tick(1);
    check({tag, "_release"}, {63'd0, dif.ready_o}, 64'd0);
  endtask

  initial begin
    tests_run        = 0;
    tests_failed     = 0;
    rst              = 1'b1;
    dif.signed_div_i = 1'b0;
    dif.opdata1_i    = '0;
    dif.opdata2_i    = '0;
    dif.start_i      = 1'b0;
    dif.annul_i      = 1'b0;
    tick(2);
    check("reset_ready",  {63'd0, dif.ready_o}, 64'd0);
    check("reset_result", dif.result_o, 64'd0);
    rst = 1'b0;
    tick(1);

    do_div("u100_7", 1'b0, 32'd100, 32'd7, {32'h0000_0002, 32'h0000_000E});
    do_div("s_m7_2", 1'b1, 32'hFFFF_FFF9, 32'h0000_0002, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    do_div("s_7_m2", 1'b1, 32'h0000_0007, 32'hFFFF_FFFE, {32'h0000_0001, 32'hFFFF_FFFD});
    do_div("s_m7_m2", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, {32'hFFFF_FFFF, 32'h0000_0003});
    do_div("u_big", 1'b0, 32'hFFFF_FFF9, 32'h0000_0002, {32'h0000_0001, 32'h7FFF_FFFC});

    // Divide by zero: BYZERO after E0, END with zero result after E1.
    drive(1'b0, 32'd5, 32'd0);
    tick(1);
    check("dz_e0_ready", {63'd0, dif.ready_o}, 64'd0);
    tick(1);
    check("dz_ready",  {63'd0, dif.ready_o}, 64'd1);
    check("dz_result", dif.result_o, 64'd0);
    tick(2);
    check("dz_hold", {63'd0, dif.ready_o}, 64'd1);
    dif.start_i = 1'b0;
    tick(1);
    check("dz_release", {63'd0, dif.ready_o}, 64'd0);

    // Annul sampled at E10, then a new start accepted at E11 completes after E44.
    drive(1'b0, 32'hFFFF_FFFF, 32'd3);
    seen_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      seen_ready |= dif.ready_o;
    end
    dif.annul_i = 1'b1;
    tick(1);
    seen_ready |= dif.ready_o;
    check("annul_no_ready",  {63'd0, seen_ready}, 64'd0);
    check("annul_result",    dif.result_o, 64'd0);
    do_div("after_annul", 1'b0, 32'd12, 32'd4, {32'd0, 32'd3});

    // Overflow with operand inputs scrambled after E0, then held for 5 cycles.
    drive(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    for (int i = 0; i < 34; i++) begin
      tick(1);
      dif.opdata1_i    = $urandom();
      dif.opdata2_i    = $urandom();
      dif.signed_div_i = 1'($urandom_range(1));
    end
    check("ovf_ready",  {63'd0, dif.ready_o}, 64'd1);
    check("ovf_result", dif.result_o, {32'h0000_0000, 32'h8000_0000});
    for (int i = 0; i < 5; i++) begin
      tick(1);
      dif.opdata1_i = $urandom();
      dif.opdata2_i = $urandom();
      check($sformatf("ovf_hold%0d", i), {dif.ready_o, dif.result_o[62:0]},
            {1'b1, 31'd0, 32'h8000_0000});
    end
    dif.start_i = 1'b0;
    tick(1);
    check("ovf_release", {63'd0, dif.ready_o}, 64'd0);

    // Reset at E15 kills the iteration; nothing completes afterwards without a new start.
    drive(1'b0, 32'd1000, 32'd3);
    tick(15);
    rst         = 1'b1;
    dif.start_i = 1'b0;
    tick(1);
    check("rst_ready",  {63'd0, dif.ready_o}, 64'd0);
    check("rst_result", dif.result_o, 64'd0);
    rst        = 1'b0;
    seen_ready = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick(1);
      seen_ready |= dif.ready_o;
    end
    check("rst_no_ready", {63'd0, seen_ready}, 64'd0);
    do_div("after_rst", 1'b0, 32'hFFFF_FFFF, 32'd1, {32'd0, 32'hFFFF_FFFF});

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
